mini_rom_arb: RTL



---
 rtl/mini_rom_arb.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mini_rom_arb.sv
// mini_rom_arb: round-robin burst reader sharing one 1-cycle-latency ROM.
// Define MINI_ROM_ARB_STAT_EN to add per-requester beat counters and a conflict pulse.
module mini_rom_arb #(
    parameter int AW = 8,
    parameter int DW = 8,
    parameter int LW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    input  logic [LW-1:0] len0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic          rlast0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    input  logic [LW-1:0] len1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic          rlast1,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_dout
`ifdef MINI_ROM_ARB_STAT_EN
    ,
    output logic [15:0]   beats0,
    output logic [15:0]   beats1,
    output logic          conflict
`endif
);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic          ptr;
    logic          ptr_nx;
    logic          owner;
    logic          owner_nx;
    logic [LW-1:0] cnt;
    logic [LW-1:0] cnt_nx;
    logic [AW-1:0] addr_nx;
    logic          gnt0_nx;
    logic          gnt1_nx;
    logic          rvalid0_nx;
    logic          rvalid1_nx;
    logic          rlast0_nx;
    logic          rlast1_nx;
    logic          win1;
    logic          last_beat;

    // ROM data is already registered, so the beat data is a plain pass-through
    assign rdata = rom_dout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            owner    <= 1'b0;
            cnt      <= '0;
            rom_addr <= '0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            rlast0   <= 1'b0;
            rlast1   <= 1'b0;
        end else begin
            state    <= state_nx;
            ptr      <= ptr_nx;
            owner    <= owner_nx;
            cnt      <= cnt_nx;
            rom_addr <= addr_nx;
            gnt0     <= gnt0_nx;
            gnt1     <= gnt1_nx;
            rvalid0  <= rvalid0_nx;
            rvalid1  <= rvalid1_nx;
            rlast0   <= rlast0_nx;
            rlast1   <= rlast1_nx;
        end
    end

    // ptr=1 means requester 1 wins a tie
    always_comb begin
        win1 = 1'b0;
        unique case (1'b1)
            req0 & ~req1: win1 = 1'b0;
            req1 & ~req0: win1 = 1'b1;
            req0 & req1:  win1 = ptr;
            default:      win1 = 1'b0;
        endcase
    end

    assign last_beat = (cnt == '0);

    always_comb begin
        state_nx   = state;
        ptr_nx     = ptr;
        owner_nx   = owner;
        cnt_nx     = cnt;
        addr_nx    = rom_addr;
        gnt0_nx    = 1'b0;
        gnt1_nx    = 1'b0;
        rvalid0_nx = 1'b0;
        rvalid1_nx = 1'b0;
        rlast0_nx  = 1'b0;
        rlast1_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_nx = BURST;
                    owner_nx = win1;
                    ptr_nx   = ~win1;
                    addr_nx  = win1 ? addr1 : addr0;
                    cnt_nx   = win1 ? len1 : len0;
                    gnt0_nx  = ~win1;
                    gnt1_nx  = win1;
                end
            end
            BURST: begin
                // the address on rom_addr now returns data next cycle
                rvalid0_nx = ~owner;
                rvalid1_nx = owner;
                rlast0_nx  = ~owner & last_beat;
                rlast1_nx  = owner & last_beat;
                if (last_beat) begin
                    state_nx = IDLE;
                end else begin
                    addr_nx = rom_addr + 1'b1;
                    cnt_nx  = cnt - 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef MINI_ROM_ARB_STAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beats0   <= '0;
            beats1   <= '0;
            conflict <= 1'b0;
        end else begin
            if (rvalid0 && beats0 != 16'hFFFF) begin
                beats0 <= beats0 + 16'd1;
            end
            if (rvalid1 && beats1 != 16'hFFFF) begin
                beats1 <= beats1 + 16'd1;
            end
            conflict <= (state == IDLE) && req0 && req1;
        end
    end
`endif

endmodule
